// File: rtl/mult_sequencer.sv
// Multi-cycle signed multiply: shift-and-add on operand magnitudes, then sign correction.
// busy stalls the PC while an operation is in flight; done pulses with result/ovf valid.
module mult_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int unsigned AccW = 2 * WIDTH;
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StSign = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic [AccW-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] mag1, mag2;
  logic [AccW-1:0]  corrected;
  logic [WIDTH:0]   upper;

  // Unsigned magnitudes: -(-128) wraps to 0x80, which is exactly 128 unsigned.
  assign mag1      = operand1[WIDTH-1] ? -operand1 : operand1;
  assign mag2      = operand2[WIDTH-1] ? -operand2 : operand2;
  assign corrected = neg_q ? -acc_q : acc_q;
  // Fits in signed WIDTH bits only if the top WIDTH+1 bits are all sign copies.
  assign upper     = corrected[AccW-1:WIDTH-1];

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    count_d  = count_q;
    neg_d    = neg_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d = {{WIDTH{1'b0}}, mag1};
          mplr_d  = mag2;
          neg_d   = operand1[WIDTH-1] ^ operand2[WIDTH-1];
          acc_d   = '0;
          count_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (mplr_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        count_d = count_q + CntW'(1);
        if (count_q == LastStep) state_d = StSign;
      end
      StSign: begin
        // result/ovf load on the edge entering DONE so they are valid with the pulse.
        acc_d    = corrected;
        result_d = corrected[WIDTH-1:0];
        ovf_d    = !((&upper) || !(|upper));
        state_d  = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule
